// File: rtl/lsu_mem_ctrl_if.sv
// Word-aligned request/grant data-memory bus between the load/store controller
// (master) and the data memory (slave).
interface lsu_mem_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory controller: splits unaligned CPU accesses into one or two
// word-aligned bus beats and reassembles/extends load data for writeback.
module lsu_mem_ctrl (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            size_data_sel,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  resp_valid,
  output logic [31:0]           rdata,
  lsu_mem_ctrl_if.master        mem
);

  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] beat0;
  logic [31:0] beat1;

  logic [1:0]  off;
  logic [3:0]  m;
  logic        split;
  logic [7:0]  be_span;
  logic [63:0] wshift;
  logic [31:0] rword;

  function automatic logic [31:0] extend(input logic [2:0] code, input logic [31:0] r);
    case (code)
      3'd0:    extend = {{24{r[7]}}, r[7:0]};
      3'd1:    extend = {{16{r[15]}}, r[15:0]};
      3'd3:    extend = {24'b0, r[7:0]};
      3'd4:    extend = {16'b0, r[15:0]};
      default: extend = r;
    endcase
  endfunction

  assign off = addr_q[1:0];

  always_comb begin
    case (size_q)
      3'd0, 3'd3: m = 4'b0001;
      3'd1, 3'd4: m = 4'b0011;
      default:    m = 4'b1111;
    endcase
  end

  assign split   = ((m == 4'b0011) && (off == 2'd3)) || ((m == 4'b1111) && (off != 2'd0));
  assign be_span = {4'b0000, m} << off;
  assign wshift  = {32'b0, wdata_q} << {off, 3'b000};
  // Upper half of the two-word window feeds the second beat of a split access.
  assign rword   = 32'({beat1, beat0} >> {off, 3'b000});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      beat0   <= 32'd0;
      beat1   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        size_q  <= size_data_sel;
        addr_q  <= addr;
        wdata_q <= wdata;
        beat0   <= 32'd0;
        beat1   <= 32'd0;
      end
      if (state == WAIT1 && mem.mem_rvalid) beat0 <= mem.mem_rdata;
      if (state == WAIT2 && mem.mem_rvalid) beat1 <= mem.mem_rdata;
    end
  end

  // Loads always read whole words; only stores narrow the byte enables.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    rdata         = 32'd0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = 32'd0;
    mem.mem_be    = 4'b0000;
    mem.mem_wdata = 32'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = REQ1;
      end
      REQ1: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = we_q;
        mem.mem_addr  = {addr_q[31:2], 2'b00};
        mem.mem_be    = we_q ? be_span[3:0] : 4'b1111;
        mem.mem_wdata = wshift[31:0];
        if (mem.mem_gnt) begin
          if (!we_q)      state_nxt = WAIT1;
          else if (split) state_nxt = REQ2;
          else            state_nxt = DONE;
        end
      end
      WAIT1: begin
        if (mem.mem_rvalid) state_nxt = split ? REQ2 : DONE;
      end
      REQ2: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = we_q;
        mem.mem_addr  = {addr_q[31:2], 2'b00} + 32'd4;
        mem.mem_be    = we_q ? be_span[7:4] : 4'b1111;
        mem.mem_wdata = wshift[63:32];
        if (mem.mem_gnt) state_nxt = we_q ? DONE : WAIT2;
      end
      WAIT2: begin
        if (mem.mem_rvalid) state_nxt = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        rdata      = we_q ? 32'd0 : extend(size_q, rword);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
